// File: rtl/riscv_pc_gen.sv
// Program-counter generator for a simple RISC-V fetch front end.
// Handles boot sequencing, sequential/branch/jalr redirects, traps, mret and halt.
module riscv_pc_gen #(
   parameter int unsigned          XLEN      = 32,
   parameter logic [XLEN-1:0]      RESET_VEC = '0,
   parameter logic [XLEN-1:0]      TRAP_VEC  = XLEN'('h100)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            advance,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] imm_ext,
   input  logic [XLEN-1:0] rs1_val,
   input  logic            trap_req,
   input  logic            mret,
   input  logic            halt_req,
   input  logic            resume,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            pc_valid,
   output logic [XLEN-1:0] epc,
   output logic            misalign_exc,
   output logic [1:0]      state
);

   typedef enum logic [1:0] {
      BOOT = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   localparam logic [1:0] SRC_BRANCH = 2'b01;
   localparam logic [1:0] SRC_JALR   = 2'b10;

   state_t          st, st_nxt;
   logic [XLEN-1:0] pc_nxt, epc_nxt;
   logic            mis_nxt;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] jalr_sum;

   assign pc_plus4 = pc + XLEN'(4);
   assign jalr_sum = rs1_val + imm_ext;

   // Target select; pc_src 11 falls through to sequential.
   always_comb begin
      target = pc_plus4;
      case (pc_src)
         SRC_BRANCH: target = pc + imm_ext;
         SRC_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
         default:    target = pc_plus4;
      endcase
   end

   always_comb begin
      st_nxt  = st;
      pc_nxt  = pc;
      epc_nxt = epc;
      mis_nxt = 1'b0;
      case (st)
         BOOT: st_nxt = RUN;
         RUN: begin
            if (trap_req) begin
               epc_nxt = pc;
               pc_nxt  = TRAP_VEC;
            end else if (mret) begin
               pc_nxt = epc;
            end else if (halt_req) begin
               st_nxt = HALT;
            end else if (advance) begin
               // A misaligned target is never loaded; it becomes a trap instead.
               if (target[1:0] != 2'b00) begin
                  epc_nxt = pc;
                  pc_nxt  = TRAP_VEC;
                  mis_nxt = 1'b1;
               end else begin
                  pc_nxt = target;
               end
            end
         end
         HALT: begin
            if (trap_req) begin
               epc_nxt = pc;
               pc_nxt  = TRAP_VEC;
               st_nxt  = RUN;
            end else if (resume) begin
               st_nxt = RUN;
            end
         end
         default: st_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st           <= BOOT;
         pc           <= RESET_VEC;
         epc          <= '0;
         misalign_exc <= 1'b0;
      end else begin
         st           <= st_nxt;
         pc           <= pc_nxt;
         epc          <= epc_nxt;
         misalign_exc <= mis_nxt;
      end
   end

   assign pc_valid = (st == RUN);
   assign state    = st;

endmodule

// File: tb/tb_riscv_pc_gen.sv
// Directed bench for riscv_pc_gen: reset, fetch, redirects, traps, halt, wrap, reset mid-trap.
module tb_riscv_pc_gen;

   logic        clk = 1'b0;
   logic        reset, advance, trap_req, mret, halt_req, resume;
   logic [1:0]  pc_src;
   logic [31:0] imm_ext, rs1_val;
   logic [31:0] pc, pc_plus4, epc;
   logic        pc_valid, misalign_exc;
   logic [1:0]  state;

   int vectors = 0;
   int miscompares = 0;

   riscv_pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100)) dut (
      .clk(clk), .reset(reset), .advance(advance), .pc_src(pc_src),
      .imm_ext(imm_ext), .rs1_val(rs1_val), .trap_req(trap_req), .mret(mret),
      .halt_req(halt_req), .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
      .pc_valid(pc_valid), .epc(epc), .misalign_exc(misalign_exc), .state(state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      advance = 0; trap_req = 0; mret = 0; halt_req = 0; resume = 0;
      pc_src = 2'b00; imm_ext = 0; rs1_val = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_epc", epc, 32'h0);
      chk("rst_state", {30'b0, state}, 32'h0);
      chk("rst_valid", {31'b0, pc_valid}, 32'h0);
      chk("rst_mis", {31'b0, misalign_exc}, 32'h0);

      // BOOT ignores advance, then sequential fetch
      reset = 0; advance = 1; pc_src = 2'b00;
      step();
      chk("boot_pc", pc, 32'h0);
      chk("boot_state", {30'b0, state}, 32'h1);
      chk("boot_valid", {31'b0, pc_valid}, 32'h1);
      chk("pc_plus4_0", pc_plus4, 32'h4);
      step(); chk("seq_4", pc, 32'h4);
      step(); chk("seq_8", pc, 32'h8);
      step(); chk("seq_c", pc, 32'hC);
      step(); chk("seq_10", pc, 32'h10);

      // branch and jalr
      pc_src = 2'b01; imm_ext = 32'hFFFF_FFF8;
      step(); chk("branch_neg", pc, 32'h8);
      pc_src = 2'b10; rs1_val = 32'h203; imm_ext = 32'h1;
      step(); chk("jalr_bit0", pc, 32'h204);
      rs1_val = 32'h20; imm_ext = 32'h0;
      step(); chk("jalr_20", pc, 32'h20);

      // misaligned branch target
      pc_src = 2'b01; imm_ext = 32'h6;
      step();
      chk("mis_pc", pc, 32'h100);
      chk("mis_epc", epc, 32'h20);
      chk("mis_pulse", {31'b0, misalign_exc}, 32'h1);
      advance = 0;
      step();
      chk("mis_clear", {31'b0, misalign_exc}, 32'h0);
      chk("mis_hold", pc, 32'h100);

      // jalr with bit 1 set traps as misaligned
      advance = 1; pc_src = 2'b10; rs1_val = 32'h41; imm_ext = 32'h1;
      step();
      chk("jalr_mis_pc", pc, 32'h100);
      chk("jalr_mis_epc", epc, 32'h100);
      chk("jalr_mis_pulse", {31'b0, misalign_exc}, 32'h1);
      rs1_val = 32'h40; imm_ext = 32'h1;
      step();
      chk("jalr_40", pc, 32'h40);
      chk("jalr_40_mis", {31'b0, misalign_exc}, 32'h0);

      // trap beats mret and advance, then mret returns
      trap_req = 1; mret = 1; advance = 1;
      step();
      chk("trap_pc", pc, 32'h100);
      chk("trap_epc", epc, 32'h40);
      chk("trap_state", {30'b0, state}, 32'h1);
      trap_req = 0; advance = 0;
      step();
      chk("mret_pc", pc, 32'h40);
      chk("mret_epc", epc, 32'h40);
      mret = 0;

      // go to 0x8, halt with advance discarded
      advance = 1; pc_src = 2'b01; imm_ext = 32'hFFFF_FFC8;
      step(); chk("br_to_8", pc, 32'h8);
      halt_req = 1;
      step();
      chk("halt_state", {30'b0, state}, 32'h2);
      chk("halt_pc", pc, 32'h8);
      chk("halt_valid", {31'b0, pc_valid}, 32'h0);
      mret = 1;
      step();
      chk("halt_ign_pc", pc, 32'h8);
      chk("halt_ign_state", {30'b0, state}, 32'h2);
      idle(); resume = 1;
      step();
      chk("resume_state", {30'b0, state}, 32'h1);
      chk("resume_pc", pc, 32'h8);

      // trap out of HALT
      idle(); halt_req = 1;
      step(); chk("halt2_state", {30'b0, state}, 32'h2);
      idle(); trap_req = 1;
      step();
      chk("halt_trap_pc", pc, 32'h100);
      chk("halt_trap_epc", epc, 32'h8);
      chk("halt_trap_state", {30'b0, state}, 32'h1);

      // wrap-around
      idle(); advance = 1; pc_src = 2'b10; rs1_val = 32'hFFFF_FFFC;
      step();
      chk("top_pc", pc, 32'hFFFF_FFFC);
      chk("top_plus4", pc_plus4, 32'h0);
      pc_src = 2'b00;
      step(); chk("wrap_pc", pc, 32'h0);
      pc_src = 2'b11;
      step(); chk("src11_seq", pc, 32'h4);

      // reset during a trap cycle discards it
      idle(); trap_req = 1; reset = 1;
      step();
      chk("rst_trap_pc", pc, 32'h0);
      chk("rst_trap_epc", epc, 32'h0);
      chk("rst_trap_state", {30'b0, state}, 32'h0);
      reset = 0; idle();
      step();
      chk("rst_boot_run", {31'b0, pc_valid}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
